// File: rtl/turn_score_ctrl.sv
// Shot/turn rules engine: tracks pockets and cue contact per shot, scores, fouls and game end.
// Optional FOUL_PENALTY_EN: a foul costs the shooter 1 point and awards the opponent 1 point.
`timescale 1ns/1ps
module turn_score_ctrl #(
  parameter int NUM_BALLS      = 6,
  parameter int SCORE_W        = 4,
  parameter int SETTLE_FRAMES  = 8,
  parameter int TIMEOUT_FRAMES = 255
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 shot_fire,
  input  logic                 balls_moving,
  input  logic [NUM_BALLS:0]   ballhole_collide,
  input  logic [NUM_BALLS:0]   balls_collide,
  output logic                 shot_enable,
  output logic                 current_player,
  output logic [SCORE_W-1:0]   score_p0,
  output logic [SCORE_W-1:0]   score_p1,
  output logic                 foul,
  output logic                 cue_respawn,
  output logic                 game_over,
  output logic [1:0]           winner
);

  localparam int CNT_W = $clog2(NUM_BALLS + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [7:0]         TIMEOUT_LIM = 8'(TIMEOUT_FRAMES);
  localparam logic [7:0]         SETTLE_LIM  = 8'(SETTLE_FRAMES);

  typedef enum logic [2:0] {
    ST_AIM,
    ST_SHOT,
    ST_SETTLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t                state_q;
  logic [NUM_BALLS:0]    pocket_mask_q;
  logic [NUM_BALLS:0]    pocket_mask_d;
  logic                  cue_contact_q;
  logic                  cue_contact_d;
  logic [NUM_BALLS:1]    total_pocketed_q;
  logic [NUM_BALLS:1]    total_pocketed_d;
  logic [7:0]            frame_cnt_q;
  logic [7:0]            frame_cnt_d;
  logic [7:0]            settle_cnt_q;
  logic [7:0]            settle_cnt_d;
  logic                  shot_enable_q;
  logic                  current_player_q;
  logic [SCORE_W-1:0]    score_p0_q;
  logic [SCORE_W-1:0]    score_p0_d;
  logic [SCORE_W-1:0]    score_p1_q;
  logic [SCORE_W-1:0]    score_p1_d;
  logic                  foul_q;
  logic                  cue_respawn_q;
  logic                  game_over_q;
  logic [1:0]            winner_q;
  logic [1:0]            winner_d;

  logic [CNT_W-1:0]      pot_cnt;
  logic                  foul_f;
  logic                  timeout_hit;
  logic                  all_pocketed;
  logic [SCORE_W-1:0]    cur_score;
  logic [SCORE_W-1:0]    opp_score;
  logic [SCORE_W:0]      cur_sum;
  logic [SCORE_W-1:0]    cur_sat;
  logic [SCORE_W-1:0]    cur_new;
  logic [SCORE_W-1:0]    opp_new;

  // Accumulation terms; the same-cycle pulse is folded in even when the state changes.
  always_comb begin
    pocket_mask_d = pocket_mask_q | ballhole_collide;
    cue_contact_d = cue_contact_q | (balls_collide[0] & (|balls_collide[NUM_BALLS:1]));
    frame_cnt_d   = frame_cnt_q + 8'd1;
    settle_cnt_d  = settle_cnt_q + 8'd1;
    timeout_hit   = startOfFrame && (frame_cnt_d == TIMEOUT_LIM);
  end

  always_comb begin
    pot_cnt = '0;
    for (int i = 1; i <= NUM_BALLS; i++) begin
      pot_cnt = pot_cnt + CNT_W'(pocket_mask_q[i]);
    end
  end

  // Evaluation of the finished shot, consumed only in ST_EVAL.
  always_comb begin
    foul_f           = pocket_mask_q[0] | ~cue_contact_q;
    total_pocketed_d = total_pocketed_q | pocket_mask_q[NUM_BALLS:1];
    all_pocketed     = &total_pocketed_d;
    cur_score        = current_player_q ? score_p1_q : score_p0_q;
    opp_score        = current_player_q ? score_p0_q : score_p1_q;
    cur_sum          = {1'b0, cur_score} + (SCORE_W + 1)'(pot_cnt);
    cur_sat          = cur_sum[SCORE_W] ? SCORE_MAX : cur_sum[SCORE_W-1:0];
`ifdef FOUL_PENALTY_EN
    if (foul_f) begin
      cur_new = (cur_sat == '0) ? '0 : cur_sat - 1'b1;
      opp_new = (opp_score == SCORE_MAX) ? SCORE_MAX : opp_score + 1'b1;
    end else begin
      cur_new = cur_sat;
      opp_new = opp_score;
    end
`else
    cur_new = cur_sat;
    opp_new = opp_score;
`endif
    score_p0_d = current_player_q ? opp_new : cur_new;
    score_p1_d = current_player_q ? cur_new : opp_new;
    if (score_p0_d > score_p1_d) begin
      winner_d = 2'b01;
    end else if (score_p1_d > score_p0_d) begin
      winner_d = 2'b10;
    end else begin
      winner_d = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q          <= ST_AIM;
      pocket_mask_q    <= '0;
      cue_contact_q    <= 1'b0;
      total_pocketed_q <= '0;
      frame_cnt_q      <= '0;
      settle_cnt_q     <= '0;
      shot_enable_q    <= 1'b1;
      current_player_q <= 1'b0;
      score_p0_q       <= '0;
      score_p1_q       <= '0;
      foul_q           <= 1'b0;
      cue_respawn_q    <= 1'b0;
      game_over_q      <= 1'b0;
      winner_q         <= 2'b00;
    end else begin
      foul_q        <= 1'b0;
      cue_respawn_q <= 1'b0;
      unique case (state_q)
        ST_AIM: begin
          if (shot_fire) begin
            state_q       <= ST_SHOT;
            shot_enable_q <= 1'b0;
            pocket_mask_q <= '0;
            cue_contact_q <= 1'b0;
            frame_cnt_q   <= '0;
            settle_cnt_q  <= '0;
          end
        end
        ST_SHOT: begin
          pocket_mask_q <= pocket_mask_d;
          cue_contact_q <= cue_contact_d;
          if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_d;
            if (timeout_hit) begin
              state_q <= ST_EVAL;
            end else if (!balls_moving) begin
              settle_cnt_q <= 8'd1;
              state_q      <= (SETTLE_LIM <= 8'd1) ? ST_EVAL : ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          pocket_mask_q <= pocket_mask_d;
          cue_contact_q <= cue_contact_d;
          if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_d;
          end
          // Any motion restarts the settle window, but the shot timeout keeps running.
          if (timeout_hit) begin
            state_q <= ST_EVAL;
          end else if (balls_moving) begin
            state_q      <= ST_SHOT;
            settle_cnt_q <= '0;
          end else if (startOfFrame) begin
            settle_cnt_q <= settle_cnt_d;
            if (settle_cnt_d == SETTLE_LIM) begin
              state_q <= ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          score_p0_q       <= score_p0_d;
          score_p1_q       <= score_p1_d;
          foul_q           <= foul_f;
          cue_respawn_q    <= pocket_mask_q[0];
          total_pocketed_q <= total_pocketed_d;
          if (foul_f || (pot_cnt == '0)) begin
            current_player_q <= ~current_player_q;
          end
          if (all_pocketed) begin
            state_q     <= ST_DONE;
            game_over_q <= 1'b1;
            winner_q    <= winner_d;
          end else begin
            state_q       <= ST_AIM;
            shot_enable_q <= 1'b1;
          end
        end
        ST_DONE: begin
          game_over_q   <= 1'b1;
          shot_enable_q <= 1'b0;
        end
        default: begin
          state_q <= ST_AIM;
        end
      endcase
    end
  end

  assign shot_enable    = shot_enable_q;
  assign current_player = current_player_q;
  assign score_p0       = score_p0_q;
  assign score_p1       = score_p1_q;
  assign foul           = foul_q;
  assign cue_respawn    = cue_respawn_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_turn_score_ctrl.sv
// Directed, table-driven bench for turn_score_ctrl; expectations follow FOUL_PENALTY_EN if defined.
`timescale 1ns/1ps
module tb_turn_score_ctrl;

  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       shot_fire;
  logic       balls_moving;
  logic [6:0] ballhole_collide;
  logic [6:0] balls_collide;
  logic       shot_enable;
  logic       current_player;
  logic [3:0] score_p0;
  logic [3:0] score_p1;
  logic       foul;
  logic       cue_respawn;
  logic       game_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  turn_score_ctrl dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .shot_fire        (shot_fire),
    .balls_moving     (balls_moving),
    .ballhole_collide (ballhole_collide),
    .balls_collide    (balls_collide),
    .shot_enable      (shot_enable),
    .current_player   (current_player),
    .score_p0         (score_p0),
    .score_p1         (score_p1),
    .foul             (foul),
    .cue_respawn      (cue_respawn),
    .game_over        (game_over),
    .winner           (winner)
  );

  typedef struct {
    logic [6:0] hole;
    logic [6:0] coll;
    logic [3:0] p0;
    logic [3:0] p1;
    logic       pl;
    logic       fl;
    logic       rs;
    logic       en;
    logic       ov;
    logic [1:0] win;
  } vec_t;

  vec_t vecs [7];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] prev_p0;
  logic [3:0] prev_p1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle from a negedge, return at the next negedge with pulses cleared.
  task automatic cyc(input logic sof, input logic fire, input logic mv,
                     input logic [6:0] hole, input logic [6:0] coll);
    startOfFrame     = sof;
    shot_fire        = fire;
    balls_moving     = mv;
    ballhole_collide = hole;
    balls_collide    = coll;
    @(negedge clk);
    startOfFrame     = 1'b0;
    shot_fire        = 1'b0;
    ballhole_collide = '0;
    balls_collide    = '0;
  endtask

  task automatic frame(input logic mv);
    cyc(1'b1, 1'b0, mv, 7'd0, 7'd0);
    cyc(1'b0, 1'b0, mv, 7'd0, 7'd0);
  endtask

  // Full shot ending one cycle after EVAL, where the evaluation results become visible.
  task automatic do_shot(input logic [6:0] hole, input logic [6:0] coll);
    cyc(1'b0, 1'b1, 1'b1, 7'd0, 7'd0);
    cyc(1'b0, 1'b0, 1'b1, hole, coll);
    frame(1'b1);
    for (int i = 0; i < SETTLE - 1; i++) frame(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    check("eval_enable_low", 8'(shot_enable), 8'd0);
    check("eval_p0_not_yet", 8'(score_p0), 8'(prev_p0));
    check("eval_p1_not_yet", 8'(score_p1), 8'(prev_p1));
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      do_shot(vecs[r].hole, vecs[r].coll);
      $display("shot %0d: p0=%0d p1=%0d player=%0d foul=%0d respawn=%0d over=%0d winner=%b",
               r, score_p0, score_p1, current_player, foul, cue_respawn, game_over, winner);
      check("row_p0", 8'(score_p0), 8'(vecs[r].p0));
      check("row_p1", 8'(score_p1), 8'(vecs[r].p1));
      check("row_player", 8'(current_player), 8'(vecs[r].pl));
      check("row_foul", 8'(foul), 8'(vecs[r].fl));
      check("row_respawn", 8'(cue_respawn), 8'(vecs[r].rs));
      check("row_enable", 8'(shot_enable), 8'(vecs[r].en));
      check("row_over", 8'(game_over), 8'(vecs[r].ov));
      check("row_winner", 8'(winner), 8'(vecs[r].win));
      prev_p0 = vecs[r].p0;
      prev_p1 = vecs[r].p1;
      cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
      check("foul_pulse_end", 8'(foul), 8'd0);
      check("respawn_pulse_end", 8'(cue_respawn), 8'd0);
    end
  endtask

  initial begin
    //                hole        coll        p0    p1    pl    fl    rs    en    ov    win
    vecs[0] = '{7'b0000100, 7'b0000011, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
`ifdef FOUL_PENALTY_EN
    vecs[1] = '{7'b0000000, 7'b0000000, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
`else
    vecs[1] = '{7'b0000000, 7'b0000000, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
`endif
    vecs[2] = '{7'b0001001, 7'b0001001, 4'd1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
    vecs[3] = '{7'b0000110, 7'b0000011, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[4] = '{7'b0011000, 7'b0000101, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
`ifdef FOUL_PENALTY_EN
    vecs[5] = '{7'b0000000, 7'b0000000, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[6] = '{7'b1100000, 7'b0000011, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
`else
    vecs[5] = '{7'b0000000, 7'b0000000, 4'd4, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[6] = '{7'b1100000, 7'b0000011, 4'd4, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
`endif

    resetN           = 1'b1;
    startOfFrame     = 1'b0;
    shot_fire        = 1'b0;
    balls_moving     = 1'b0;
    ballhole_collide = '0;
    balls_collide    = '0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    resetN = 1'b0;
    check("rst_enable", 8'(shot_enable), 8'd1);
    check("rst_player", 8'(current_player), 8'd0);
    check("rst_p0", 8'(score_p0), 8'd0);
    check("rst_p1", 8'(score_p1), 8'd0);
    check("rst_foul", 8'(foul), 8'd0);
    check("rst_respawn", 8'(cue_respawn), 8'd0);
    check("rst_over", 8'(game_over), 8'd0);
    check("rst_winner", 8'(winner), 8'd0);

    // Reset asserted for two clocks in the middle of a shot.
    cyc(1'b0, 1'b1, 1'b1, 7'd0, 7'd0);
    cyc(1'b0, 1'b0, 1'b1, 7'b0000010, 7'b0000011);
    frame(1'b1);
    check("midshot_enable", 8'(shot_enable), 8'd0);
    resetN = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 7'b0000100, 7'd0);
    cyc(1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    resetN = 1'b0;
    check("midrst_enable", 8'(shot_enable), 8'd1);
    check("midrst_player", 8'(current_player), 8'd0);
    check("midrst_p0", 8'(score_p0), 8'd0);
    check("midrst_p1", 8'(score_p1), 8'd0);
    $display("reset mid-shot: enable=%0d player=%0d p0=%0d p1=%0d",
             shot_enable, current_player, score_p0, score_p1);

    prev_p0 = 4'd0;
    prev_p1 = 4'd0;
    run_rows(0, 2);

    // Settle interrupted after 5 still frames; ball 2 pocketed twice in one shot.
    cyc(1'b0, 1'b1, 1'b1, 7'd0, 7'd0);
    cyc(1'b0, 1'b0, 1'b1, 7'b0000100, 7'b0000011);
    cyc(1'b0, 1'b0, 1'b1, 7'b0000100, 7'd0);
    frame(1'b1);
    for (int i = 0; i < 5; i++) frame(1'b0);
    frame(1'b1);
    for (int i = 0; i < SETTLE - 1; i++) frame(1'b0);
    check("interrupt_no_early_eval", 8'(score_p0), 8'd1);
    check("interrupt_still_busy", 8'(shot_enable), 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    check("interrupt_latency", 8'(score_p0), 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    $display("settle interrupt: p0=%0d p1=%0d player=%0d foul=%0d",
             score_p0, score_p1, current_player, foul);
    check("interrupt_p0", 8'(score_p0), 8'd2);
    check("interrupt_p1", 8'(score_p1), 8'd1);
    check("interrupt_player", 8'(current_player), 8'd0);
    check("interrupt_foul", 8'(foul), 8'd0);
    check("interrupt_enable", 8'(shot_enable), 8'd1);

    // Fresh game played to completion.
    resetN = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    resetN = 1'b0;
    prev_p0 = 4'd0;
    prev_p1 = 4'd0;
    run_rows(3, 6);

    // A shot attempt after game end must change nothing.
    cyc(1'b0, 1'b1, 1'b1, 7'd0, 7'd0);
    cyc(1'b0, 1'b0, 1'b1, 7'b0000110, 7'b0000011);
    for (int i = 0; i < SETTLE + 1; i++) frame(1'b0);
    $display("post-game fire: p0=%0d p1=%0d over=%0d winner=%b enable=%0d",
             score_p0, score_p1, game_over, winner, shot_enable);
    check("post_enable", 8'(shot_enable), 8'd0);
    check("post_over", 8'(game_over), 8'd1);
    check("post_winner", 8'(winner), 8'(vecs[6].win));
    check("post_p0", 8'(score_p0), 8'(vecs[6].p0));
    check("post_p1", 8'(score_p1), 8'(vecs[6].p1));
    check("post_foul", 8'(foul), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
